// File: rtl/jtkunio_mcu_mbox.sv
// MCU-side end of the main-CPU <-> 6801 MCU mailbox.
// One byte latch per direction, each owned by a two-state (EMPTY/FULL) FSM.
// MCU port-2 strobes are edge-detected on cen so a held strobe gives one event.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cen                 MCU clock enable, gates port-2 sampling only
//   main_wr, main_clr   main CPU write / status-clear pulses (one clk each)
//   main_dout           main CPU data, valid with main_wr
//   mcu_p1_out          MCU reply byte
//   mcu_p2_out          MCU strobes (WRN_BIT write, RDN_BIT read, active low)
//   mcu_p1_in           byte from main CPU to MCU port 1
//   mcu_p3_in           {4'd0,2'b11,mcu_stn,~mcu_irq} to MCU port 3
//   mcu_irq             high while a main->MCU byte is pending
//   main_din            MCU reply byte to the main CPU
//   mcu_stn             low while an MCU->main byte is pending
//   ovr_m2s, ovr_s2m    sticky overrun flags per direction
`timescale 1ns/1ps
module jtkunio_mcu_mbox #(
    parameter int unsigned WRN_BIT = 2,
    parameter int unsigned RDN_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       main_wr,
    input  logic       main_clr,
    input  logic [7:0] main_dout,
    input  logic [7:0] mcu_p1_out,
    input  logic [7:0] mcu_p2_out,
    output logic [7:0] mcu_p1_in,
    output logic [7:0] mcu_p3_in,
    output logic       mcu_irq,
    output logic [7:0] main_din,
    output logic       mcu_stn,
    output logic       ovr_m2s,
    output logic       ovr_s2m
);

    localparam logic [7:0] WR_MASK = 8'(8'd1 << WRN_BIT);
    localparam logic [7:0] RD_MASK = 8'(8'd1 << RDN_BIT);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } box_e;

    box_e m2s_st, m2s_nx;
    box_e s2m_st, s2m_nx;

    logic       wr_prev, rd_prev;
    logic       wr_lvl_c, rd_lvl_c;
    logic       wr_ev_c, rd_ev_c;
    logic [7:0] p1_in_nx, din_nx;
    logic       ovr_m2s_nx, ovr_s2m_nx;

    // Strobe levels read through masks so the whole port is consumed
    assign wr_lvl_c = |(mcu_p2_out & WR_MASK);
    assign rd_lvl_c = |(mcu_p2_out & RD_MASK);

    // Falling-edge events, sampled only on MCU clock enables
    assign wr_ev_c = cen & wr_prev & ~wr_lvl_c;
    assign rd_ev_c = cen & rd_prev & ~rd_lvl_c;

    assign mcu_p3_in = {4'd0, 2'b11, mcu_stn, ~mcu_irq};

    // Strobe history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_prev <= 1'b1;
            rd_prev <= 1'b1;
        end else if (cen) begin
            wr_prev <= wr_lvl_c;
            rd_prev <= rd_lvl_c;
        end
    end

    // State and output registers for both directions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m2s_st    <= EMPTY;
            s2m_st    <= EMPTY;
            mcu_p1_in <= 8'd0;
            main_din  <= 8'd0;
            mcu_irq   <= 1'b0;
            mcu_stn   <= 1'b1;
            ovr_m2s   <= 1'b0;
            ovr_s2m   <= 1'b0;
        end else begin
            m2s_st    <= m2s_nx;
            s2m_st    <= s2m_nx;
            mcu_p1_in <= p1_in_nx;
            main_din  <= din_nx;
            mcu_irq   <= (m2s_nx == FULL);
            mcu_stn   <= (s2m_nx != FULL);
            ovr_m2s   <= ovr_m2s_nx;
            ovr_s2m   <= ovr_s2m_nx;
        end
    end

    // Main->MCU: a new write always wins over a read or clear in the same clk
    always_comb begin
        m2s_nx     = m2s_st;
        p1_in_nx   = mcu_p1_in;
        ovr_m2s_nx = ovr_m2s;
        case (m2s_st)
            EMPTY: begin
                if (main_wr) begin
                    m2s_nx   = FULL;
                    p1_in_nx = main_dout;
                end
            end
            FULL: begin
                if (main_wr) begin
                    p1_in_nx   = main_dout;
                    ovr_m2s_nx = 1'b1;
                end else if (rd_ev_c || main_clr) begin
                    m2s_nx = EMPTY;
                end
            end
            default: m2s_nx = EMPTY;
        endcase
    end

    // MCU->main: a new MCU write wins over a clear; main_din survives the clear
    always_comb begin
        s2m_nx     = s2m_st;
        din_nx     = main_din;
        ovr_s2m_nx = ovr_s2m;
        case (s2m_st)
            EMPTY: begin
                if (wr_ev_c) begin
                    s2m_nx = FULL;
                    din_nx = mcu_p1_out;
                end
            end
            FULL: begin
                if (wr_ev_c) begin
                    din_nx     = mcu_p1_out;
                    ovr_s2m_nx = 1'b1;
                end else if (main_clr) begin
                    s2m_nx = EMPTY;
                end
            end
            default: s2m_nx = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_jtkunio_mcu_mbox.sv
`timescale 1ns/1ps
module tb_jtkunio_mcu_mbox;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic       main_wr;
    logic       main_clr;
    logic [7:0] main_dout;
    logic [7:0] mcu_p1_out;
    logic [7:0] mcu_p2_out;
    logic [7:0] mcu_p1_in;
    logic [7:0] mcu_p3_in;
    logic       mcu_irq;
    logic [7:0] main_din;
    logic       mcu_stn;
    logic       ovr_m2s;
    logic       ovr_s2m;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] p1;
        logic [7:0] din;
        logic       irq;
        logic       stn;
        logic       om;
        logic       os;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [7:0] m_p1, m_din;
    logic       m_irq, m_stn, m_om, m_os, m_wrp, m_rdp;

    jtkunio_mcu_mbox dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .main_wr    (main_wr),
        .main_clr   (main_clr),
        .main_dout  (main_dout),
        .mcu_p1_out (mcu_p1_out),
        .mcu_p2_out (mcu_p2_out),
        .mcu_p1_in  (mcu_p1_in),
        .mcu_p3_in  (mcu_p3_in),
        .mcu_irq    (mcu_irq),
        .main_din   (main_din),
        .mcu_stn    (mcu_stn),
        .ovr_m2s    (ovr_m2s),
        .ovr_s2m    (ovr_s2m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.p1 = m_p1; e.din = m_din; e.irq = m_irq;
        e.stn = m_stn; e.om = m_om; e.os = m_os;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL %s got=empty-scoreboard exp=entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".p1_in"},  mcu_p1_in, e.p1);
        chk({tag, ".din"},    main_din,  e.din);
        chk({tag, ".irq"},    8'(mcu_irq), 8'(e.irq));
        chk({tag, ".stn"},    8'(mcu_stn), 8'(e.stn));
        chk({tag, ".ovr_m2s"}, 8'(ovr_m2s), 8'(e.om));
        chk({tag, ".ovr_s2m"}, 8'(ovr_s2m), 8'(e.os));
        chk({tag, ".p3_in"},  mcu_p3_in, {4'd0, 2'b11, e.stn, ~e.irq});
    endtask

    task automatic model_reset();
        m_p1 = 8'd0; m_din = 8'd0; m_irq = 1'b0; m_stn = 1'b1;
        m_om = 1'b0; m_os = 1'b0; m_wrp = 1'b1; m_rdp = 1'b1;
    endtask

    // Asynchronous reset: outputs checked while rst is still high
    task automatic do_reset(input string tag);
        rst = 1'b1; cen = 1'b0; main_wr = 1'b0; main_clr = 1'b0;
        mcu_p2_out = 8'hFF;
        #2;
        model_reset();
        push_model();
        pop_check(tag);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clk of stimulus; model advanced, expectation queued, checked after the edge
    task automatic step(input string tag, input logic c, input logic w, input logic cl,
                        input logic [7:0] d, input logic [7:0] p1o, input logic [7:0] p2o);
        logic wev, rev;
        cen = c; main_wr = w; main_clr = cl; main_dout = d;
        mcu_p1_out = p1o; mcu_p2_out = p2o;
        wev = c & m_wrp & ~p2o[2];
        rev = c & m_rdp & ~p2o[1];
        if (c) begin
            m_wrp = p2o[2];
            m_rdp = p2o[1];
        end
        if (w) begin
            if (m_irq) m_om = 1'b1;
            m_irq = 1'b1;
            m_p1  = d;
        end else if (rev || cl) begin
            m_irq = 1'b0;
        end
        if (wev) begin
            if (!m_stn) m_os = 1'b1;
            m_stn = 1'b0;
            m_din = p1o;
        end else if (cl) begin
            m_stn = 1'b1;
        end
        push_model();
        @(posedge clk); #1;
        pop_check(tag);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; main_wr = 1'b0; main_clr = 1'b0;
        main_dout = 8'h00; mcu_p1_out = 8'h00; mcu_p2_out = 8'hFF;
        model_reset();
        #1;
        do_reset("reset0");

        // Fill both directions, then reset mid-transfer
        step("pre_wr", 1'b1, 1'b1, 1'b0, 8'hA0, 8'h5A, 8'hFF);
        step("pre_sw", 1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 8'hFB);
        do_reset("reset_mid");

        // Main write reaches MCU port 1 and raises the interrupt
        step("wr_a5", 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 8'hFF);

        // Read strobe held for 10 cen: one event only
        for (int i = 0; i < 10; i++)
            step("rd_hold", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFD);
        step("rd_rel", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF);

        // MCU reply, then status clear keeps the byte
        step("mcu_wr", 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 8'hFB);
        step("mcu_rel", 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 8'hFF);
        step("clr", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF);

        // Main overrun
        step("wr_11", 1'b1, 1'b1, 1'b0, 8'h11, 8'h00, 8'hFF);
        step("wr_22", 1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 8'hFF);

        // MCU overrun
        step("sw_55", 1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 8'hFB);
        step("sw_rel", 1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 8'hFF);
        step("sw_66", 1'b1, 1'b0, 1'b0, 8'h00, 8'h66, 8'hFB);
        step("sw_rel2", 1'b1, 1'b0, 1'b0, 8'h00, 8'h66, 8'hFF);

        // Main write beats MCU read in the same clk
        step("wr_vs_rd", 1'b1, 1'b1, 1'b0, 8'h77, 8'h00, 8'hFD);
        step("rd_rel2", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF);

        // MCU write beats clear in the same clk
        step("clr_pre", 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF);
        step("clr_vs_wr", 1'b1, 1'b0, 1'b1, 8'h00, 8'h48, 8'hFB);
        step("sw_rel3", 1'b1, 1'b0, 1'b0, 8'h00, 8'h48, 8'hFF);
        step("clr2", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF);

        // Strobe low with cen=0 has no effect until cen returns
        for (int i = 0; i < 5; i++)
            step("cen_off", 1'b0, 1'b0, 1'b0, 8'h00, 8'h9A, 8'hFB);
        step("cen_on", 1'b1, 1'b0, 1'b0, 8'h00, 8'h9A, 8'hFB);
        step("cen_hold", 1'b1, 1'b0, 1'b0, 8'h00, 8'hB1, 8'hFB);

        // Random mix against the model
        for (int i = 0; i < 60; i++) begin
            logic [7:0] p2;
            p2 = 8'hF9 | 8'(($urandom_range(0, 3)) << 1);
            step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), p2);
        end

        do_reset("reset_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
